// File: rtl/uart_boot_loader.sv
// Turns a framed UART download (A5, LEN_LO, LEN_HI, 4*N data bytes, CSUM) into ROM word writes.
// Latency: erase/write strobes one cycle after the triggering byte; rx never back-pressured, tx waits on tx_ready_i.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        rom_erase_en_o,
    output logic        rom_wr_en_o,
    output logic [31:0] rom_wr_addr_o,
    output logic [31:0] rom_wr_data_o,
    output logic        cpu_hold_o
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  ST_OK    = 8'h4F;
    localparam logic [7:0]  ST_ERR   = 8'h45;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   asm_word;
    logic [7:0]    csum;
    logic [31:0]   addr;
    logic [7:0]    status;
    logic [TW-1:0] timer;
    logic          erase_q;
    logic          wr_en_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;

    logic hdr_hit;
    logic word_done;
    logic timeout_hit;
    logic tmo_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hdr_hit     = 1'b0;
        word_done   = 1'b0;
        tmo_active  = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CSUM);
        timeout_hit = tmo_active && !rx_valid_i && (timer == TMO_LAST);
        case (state)
            IDLE: begin
                if (rx_valid_i && (rx_data_i == HDR_BYTE)) begin
                    hdr_hit   = 1'b1;
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: if (rx_valid_i) state_nxt = LEN_HI;
            LEN_HI: begin
                if (rx_valid_i)
                    state_nxt = ({rx_data_i, len[7:0]} != 16'd0) ? DATA : CSUM;
            end
            DATA: begin
                if (rx_valid_i && (byte_idx == 2'd3)) begin
                    word_done = 1'b1;
                    if ((word_cnt + 16'd1) == len) state_nxt = CSUM;
                end
            end
            CSUM: if (rx_valid_i) state_nxt = RESP;
            RESP: if (tx_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // timeout only fires on a cycle without a byte, so it never races a transition above
        if (timeout_hit) state_nxt = RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            csum      <= '0;
            addr      <= '0;
            status    <= '0;
            timer     <= '0;
            erase_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            erase_q <= hdr_hit;
            wr_en_q <= word_done;

            if (!tmo_active || rx_valid_i) timer <= '0;
            else                           timer <= timer + 1'b1;

            if (hdr_hit) begin
                addr     <= BASE_ADDR;
                csum     <= '0;
                byte_idx <= '0;
                word_cnt <= '0;
                len      <= '0;
            end

            if ((state == LEN_LO) && rx_valid_i) len[7:0]  <= rx_data_i;
            if ((state == LEN_HI) && rx_valid_i) len[15:8] <= rx_data_i;

            if ((state == DATA) && rx_valid_i) begin
                asm_word <= {rx_data_i, asm_word[23:8]};
                csum     <= csum + rx_data_i;
                byte_idx <= byte_idx + 2'd1;
            end

            if (word_done) begin
                wr_addr_q <= addr;
                wr_data_q <= {rx_data_i, asm_word};
                addr      <= addr + 32'd4;
                word_cnt  <= word_cnt + 16'd1;
            end

            if ((state == CSUM) && rx_valid_i)
                status <= (rx_data_i == csum) ? ST_OK : ST_ERR;
            if (timeout_hit)
                status <= ST_ERR;
        end
    end

    assign tx_valid_o     = (state == RESP);
    assign tx_data_o      = tx_valid_o ? status : 8'h00;
    assign cpu_hold_o     = (state != IDLE);
    assign rom_erase_en_o = erase_q;
    assign rom_wr_en_o    = wr_en_q;
    assign rom_wr_addr_o  = wr_addr_q;
    assign rom_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed frame vectors plus hand-written timeout, back-pressure and mid-frame reset sequences.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        rom_erase_en_o;
    logic        rom_wr_en_o;
    logic [31:0] rom_wr_addr_o;
    logic [31:0] rom_wr_data_o;
    logic        cpu_hold_o;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (1000),
        .HDR_BYTE       (8'hA5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_valid_i     (rx_valid),
        .rx_data_i      (rx_data),
        .tx_valid_o     (tx_valid_o),
        .tx_data_o      (tx_data_o),
        .tx_ready_i     (tx_ready),
        .rom_erase_en_o (rom_erase_en_o),
        .rom_wr_en_o    (rom_wr_en_o),
        .rom_wr_addr_o  (rom_wr_addr_o),
        .rom_wr_data_o  (rom_wr_data_o),
        .cpu_hold_o     (cpu_hold_o)
    );

    typedef struct {
        logic [127:0] stream;   // first byte in bits 127:120
        int           nb;
        bit           burst;
        int           n_wr;
        logic [31:0]  a0, d0, a1, d1;
        logic [7:0]   tx;
    } vec_t;

    vec_t vecs[5];

    int total = 0;
    int bad   = 0;

    int          n_erase = 0;
    int          early_drop = 0;
    int          erase_no_hold = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  tx_q[$];
    logic        prev_hold = 1'b0;
    logic        prev_hs = 1'b0;

    always @(negedge clk) begin
        if (rom_erase_en_o) n_erase++;
        if (rom_erase_en_o && !cpu_hold_o) erase_no_hold++;
        if (rom_wr_en_o) begin
            wa_q.push_back(rom_wr_addr_o);
            wd_q.push_back(rom_wr_data_o);
        end
        if (tx_valid_o && tx_ready) tx_q.push_back(tx_data_o);
        if (rst_n && prev_hold && !cpu_hold_o && !prev_hs) early_drop++;
        prev_hs   = tx_valid_o && tx_ready;
        prev_hold = cpu_hold_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit burst);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        if (!burst) begin
            tick();
            tick();
        end
    endtask

    task automatic clear_mon();
        n_erase = 0;
        wa_q.delete();
        wd_q.delete();
        tx_q.delete();
    endtask

    task automatic wait_tx(input string name);
        int k;
        k = 0;
        while (tx_q.size() == 0 && k < 3000) begin
            tick();
            k++;
        end
        check({name, "_tx_seen"}, 32'(tx_q.size()), 32'd1);
        @(negedge clk);
        check({name, "_hold_after"}, 32'(cpu_hold_o), 32'd0);
        check({name, "_txv_after"}, 32'(tx_valid_o), 32'd0);
        tick();
    endtask

    task automatic apply_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        clear_mon();
        for (int k = 0; k < vecs[i].nb; k++)
            send_byte(vecs[i].stream[127-8*k -: 8], vecs[i].burst);
        wait_tx(nm);
        check({nm, "_erase"}, 32'(n_erase), 32'd1);
        check({nm, "_nwr"}, 32'(wa_q.size()), 32'(vecs[i].n_wr));
        if (vecs[i].n_wr > 0 && wa_q.size() > 0) begin
            check({nm, "_a0"}, wa_q[0], vecs[i].a0);
            check({nm, "_d0"}, wd_q[0], vecs[i].d0);
        end
        if (vecs[i].n_wr > 1 && wa_q.size() > 1) begin
            check({nm, "_a1"}, wa_q[1], vecs[i].a1);
            check({nm, "_d1"}, wd_q[1], vecs[i].d1);
        end
        if (tx_q.size() > 0)
            check({nm, "_status"}, 32'(tx_q[0]), 32'(vecs[i].tx));
    endtask

    initial begin
        int k;
        int bp_bad;

        // garbage, then two-word frame; checksum 0x4C is the mod-256 sum of the eight data bytes
        vecs[0] = '{128'h0011A5020078563412EFBEADDE4C_0000, 14, 1'b0, 2,
                    32'h0, 32'h1234_5678, 32'h4, 32'hDEAD_BEEF, 8'h4F};
        vecs[1] = '{128'hA5020078563412EFBEADDE47_0000_0000, 12, 1'b1, 2,
                    32'h0, 32'h1234_5678, 32'h4, 32'hDEAD_BEEF, 8'h45};
        vecs[2] = '{128'hA5000000_0000_0000_0000_0000_0000_0000, 4, 1'b0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 8'h4F};
        vecs[3] = '{128'hA50100010203040A_0000_0000_0000_0000, 8, 1'b1, 1,
                    32'h0, 32'h0403_0201, 32'h0, 32'h0, 8'h4F};
        vecs[4] = '{128'h5AA50100FFFFFFFFFC_00_0000_0000_0000, 9, 1'b0, 1,
                    32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 8'h4F};

        #2;
        check("rst_ctrl", {20'd0, tx_valid_o, tx_data_o, rom_erase_en_o, rom_wr_en_o, cpu_hold_o}, 32'd0);
        check("rst_addr", rom_wr_addr_o, 32'd0);
        check("rst_data", rom_wr_data_o, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) apply_vec(i);

        // timeout: one-word frame stops after two data bytes
        clear_mon();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!tx_valid_o && k < 3000);
        check("tmo_latency", 32'(k), 32'd1000);
        check("tmo_status", 32'(tx_data_o), 32'h45);
        check("tmo_hold", 32'(cpu_hold_o), 32'd1);
        check("tmo_nwr", 32'(wa_q.size()), 32'd0);
        tick();
        wait_tx("tmo");
        apply_vec(0);

        // back-pressure: response held while tx_ready is low; a header byte in RESP is ignored
        tx_ready = 1'b0;
        clear_mon();
        for (int j = 0; j < vecs[3].nb; j++)
            send_byte(vecs[3].stream[127-8*j -: 8], 1'b1);
        bp_bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (!(tx_valid_o === 1'b1 && tx_data_o === 8'h4F && cpu_hold_o === 1'b1)) bp_bad++;
            rx_valid = (j == 5);
            rx_data  = 8'hA5;
        end
        rx_valid = 1'b0;
        check("bp_stable", 32'(bp_bad), 32'd0);
        tick();
        check("bp_erase", 32'(n_erase), 32'd1);
        tx_ready = 1'b1;
        wait_tx("bp");
        if (tx_q.size() > 0) check("bp_status", 32'(tx_q[0]), 32'h4F);
        check("bp_nwr", 32'(wa_q.size()), 32'd1);

        // reset after six data bytes of a four-word frame
        clear_mon();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int j = 1; j <= 6; j++) send_byte(8'(j), 1'b0);
        check("mid_hold", 32'(cpu_hold_o), 32'd1);
        check("mid_wdata", rom_wr_data_o, 32'h0403_0201);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {20'd0, tx_valid_o, tx_data_o, rom_erase_en_o, rom_wr_en_o, cpu_hold_o}, 32'd0);
        check("mid_rst_addr", rom_wr_addr_o, 32'd0);
        check("mid_rst_data", rom_wr_data_o, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 30; j++) tick();
        check("mid_no_tx", 32'(tx_q.size()), 32'd0);
        apply_vec(3);

        check("hold_early_drop", 32'(early_drop), 32'd0);
        check("erase_without_hold", 32'(erase_no_hold), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
